// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Sequential 32-bit signed divider for the DIV instruction. It
//             performs one restoring-division step per clock on operand
//             magnitudes, then applies signs so the quotient truncates toward
//             zero and the remainder takes the sign of the dividend.
//  Ports    : clk      - system clock, rising edge
//             reset    - synchronous, active-high reset
//             start    - request a division (sampled only when idle)
//             a, b     - dividend / divisor, two's complement
//             hi, lo   - remainder / quotient of the last completed division
//             busy     - division in progress
//             done     - one-cycle completion pulse
//             div_zero - one-cycle pulse with done when the divisor was zero
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_count;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic        r_sign_q;
    logic        r_sign_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_div_zero;

    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [33:0] w_shift_rem;
    logic [33:0] w_trial;

    assign w_b_zero = (b == 32'd0);
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
    // magnitude 2^31, so the most-negative operand needs no special case.
    assign w_a_mag  = a[31] ? -a : a;
    assign w_b_mag  = b[31] ? -b : b;

    // The partial remainder is always below the divisor, so after the shift it
    // fits in 33 bits; one extra bit keeps the trial-subtract borrow visible.
    assign w_shift_rem = {r_rem, r_quo[31]};
    assign w_trial     = w_shift_rem - {2'b00, r_divisor};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start && !w_b_zero) begin
                    w_state_next = c_CALC;
                end
            end
            c_CALC: begin
                if (r_count == 5'd31) begin
                    w_state_next = c_FIX;
                end
            end
            c_FIX:   w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 5'd0;
            r_rem      <= 33'd0;
            r_quo      <= 32'd0;
            r_divisor  <= 32'd0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_b_zero) begin
                            // Flag immediately; results are left untouched.
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_quo     <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_sign_q  <= a[31] ^ b[31];
                            r_sign_r  <= a[31];
                            r_rem     <= 33'd0;
                            r_count   <= 5'd0;
                        end
                    end
                end
                c_CALC: begin
                    // r_quo doubles as the dividend shift register: dividend
                    // bits leave at the top while quotient bits enter below.
                    if (!w_trial[33]) begin
                        r_rem <= w_trial[32:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift_rem[32:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_count <= r_count + 5'd1;
                end
                c_FIX: begin
                    r_lo   <= r_sign_q ? -r_quo : r_quo;
                    r_hi   <= r_sign_r ? -r_rem[31:0] : r_rem[31:0];
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state == c_CALC) || (r_state == c_FIX);
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Directed self-checking bench for div_unit. Each operation is
//             started on edge E0; the bench then samples 1 ns after every
//             following edge, recording when done appears, how many samples
//             show busy, and whether div_zero accompanied done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks;
    int n_errors;

    div_unit u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts a division on edge E0 and observes n_cycles sample points.
    // poke_at >= 0 disturbs the run after sample poke_at: either a one-cycle
    // reset, or a one-cycle start with a=1, b=1 (which must be ignored).
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input int poke_at, input bit poke_reset, input int n_cycles,
                          output int first_done, output int done_cnt,
                          output int busy_cnt, output bit dz_seen);
        first_done = -1;
        done_cnt   = 0;
        busy_cnt   = 0;
        dz_seen    = 1'b0;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < n_cycles; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                if (div_zero) dz_seen = 1'b1;
            end
            if (poke_at >= 0 && i == poke_at + 1) begin
                if (poke_reset) begin
                    check({tag, " rst hi"},       hi,               32'd0);
                    check({tag, " rst lo"},       lo,               32'd0);
                    check({tag, " rst busy"},     {31'd0, busy},    32'd0);
                    check({tag, " rst done"},     {31'd0, done},    32'd0);
                    check({tag, " rst div_zero"}, {31'd0, div_zero}, 32'd0);
                end
                reset = 1'b0;
                start = 1'b0;
            end
            if (i == poke_at) begin
                if (poke_reset) begin
                    reset = 1'b1;
                end else begin
                    start = 1'b1;
                    a     = 32'd1;
                    b     = 32'd1;
                end
            end
        end
    endtask

    // Normal division: done is first seen after E33, exactly once; busy is
    // seen after E0 through E32 (33 samples); no div_zero.
    task automatic run_normal(input string tag, input logic [31:0] av, input logic [31:0] bv,
                              input int poke_at, input logic [31:0] exp_lo,
                              input logic [31:0] exp_hi, input bit full);
        int  fd, dc, bc;
        bit  dz;
        run_op(tag, av, bv, poke_at, 1'b0, 38, fd, dc, bc, dz);
        if (full) begin
            check({tag, " done edge"},  32'(fd), 32'd33);
            check({tag, " done count"}, 32'(dc), 32'd1);
            check({tag, " busy count"}, 32'(bc), 32'd33);
            check({tag, " div_zero"},   {31'd0, dz}, 32'd0);
        end
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " hi"}, hi, exp_hi);
    endtask

    initial begin
        int fd, dc, bc;
        bit dz;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset hi",       hi,                32'd0);
        check("reset lo",       lo,                32'd0);
        check("reset busy",     {31'd0, busy},     32'd0);
        check("reset done",     {31'd0, done},     32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);

        run_normal("7/2",   32'd7,          32'd2,          -1, 32'd3,          32'd1,          1'b1);
        run_normal("-7/2",  32'hFFFF_FFF9,  32'd2,          -1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_normal("7/-2",  32'd7,          32'hFFFF_FFFE,  -1, 32'hFFFF_FFFD,  32'd1,          1'b0);
        // Second start at CALC step 5 must not disturb the running division.
        run_normal("poke",  32'd100,        32'd7,           5, 32'd14,         32'd2,          1'b1);
        run_normal("min/-1", 32'h8000_0000, 32'hFFFF_FFFF,  -1, 32'h8000_0000,  32'd0,          1'b1);
        run_normal("100/7", 32'd100,        32'd7,          -1, 32'd14,         32'd2,          1'b0);

        // Divide by zero: flagged right after E0, no busy, results held.
        run_op("dz", 32'd5, 32'd0, -1, 1'b0, 10, fd, dc, bc, dz);
        check("dz done edge",  32'(fd), 32'd0);
        check("dz done count", 32'(dc), 32'd1);
        check("dz busy count", 32'(bc), 32'd0);
        check("dz div_zero",   {31'd0, dz}, 32'd1);
        check("dz lo held",    lo, 32'd14);
        check("dz hi held",    hi, 32'd2);

        // Reset at CALC step 10 aborts the division; no done afterwards.
        run_op("abort", 32'd100, 32'd7, 10, 1'b1, 55, fd, dc, bc, dz);
        check("abort done count", 32'(dc), 32'd0);
        check("abort lo",         lo, 32'd0);

        run_normal("9/3", 32'd9, 32'd3, -1, 32'd3, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
